// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Polarity constants describe the common-anode board wiring.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic       ANODE_OFF  = 1'b1;
  localparam logic       SEG_OFF    = 1'b1;

  // 0.5 ms lit + 5 us guard per digit at 100 MHz
  localparam int DEF_SCAN_DIV     = 50000;
  localparam int DEF_GUARD_CYCLES = 500;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_lz_blank.sv
// Leading-zero suppress mask: digit i>0 is suppressed when it and every higher digit are zero.
// Takes digits 1..NUM_DIGITS-1 only; digit 0 is never suppressed.
module seg_lz_blank #(
  parameter int NUM_DIGITS = 4,
  parameter int LZ_BLANK   = 1
) (
  input  logic [4*(NUM_DIGITS-1)-1:0] hi_bcd_i,
  output logic [NUM_DIGITS-1:0]       suppress_o
);

  logic zero_run;

  always_comb begin
    suppress_o = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run & (hi_bcd_i[4*(i-1) +: 4] == 4'h0);
      suppress_o[i] = (LZ_BLANK != 0) & zero_run;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with guard gaps and frame-aligned word updates.
// All outputs are registered from next-state so anodes and codes switch on the same edge.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_bcd,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              digit_bcd_q, digit_bcd_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_start_q, frame_start_d;
  logic                    upd_ready_q;
  logic                    accept;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   suppress;

  assign accept = upd_valid && upd_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;
    boundary     = 1'b0;

    if (!en) begin
      // Parked so that re-enable starts a fresh frame at digit 0
      state_d = GUARD;
      cnt_d   = '0;
      idx_d   = LAST_IDX;
    end else begin
      case (state_q)
        GUARD: begin
          if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
            state_d  = SHOW;
            cnt_d    = '0;
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            boundary = (idx_q == LAST_IDX);
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            state_d = GUARD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = GUARD;
          cnt_d   = '0;
        end
      endcase
    end

    // Consume needs pend_full, which holds ready low, so it never coincides with accept
    if (boundary && pend_full_q) begin
      shadow_bcd_d = pend_bcd_q;
      shadow_dp_d  = pend_dp_q;
      pend_full_d  = 1'b0;
    end
    if (accept) begin
      pend_bcd_d  = upd_bcd;
      pend_dp_d   = upd_dp;
      pend_full_d = 1'b1;
    end
  end

  seg_lz_blank #(
    .NUM_DIGITS (NUM_DIGITS),
    .LZ_BLANK   (LZ_BLANK)
  ) u_lz (
    .hi_bcd_i   (shadow_bcd_d[4*NUM_DIGITS-1:4]),
    .suppress_o (suppress)
  );

  always_comb begin
    an_n_d        = {NUM_DIGITS{ANODE_OFF}};
    digit_bcd_d   = BLANK_CODE;
    dp_n_d        = SEG_OFF;
    frame_start_d = boundary;
    if (state_d == SHOW) begin
      an_n_d[idx_d] = ~ANODE_OFF;
      digit_bcd_d   = suppress[idx_d] ? BLANK_CODE : shadow_bcd_d[4*idx_d +: 4];
      dp_n_d        = ~shadow_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= GUARD;
      cnt_q         <= '0;
      idx_q         <= LAST_IDX;
      shadow_bcd_q  <= {NUM_DIGITS{BLANK_CODE}};
      shadow_dp_q   <= '0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      an_n_q        <= {NUM_DIGITS{ANODE_OFF}};
      digit_bcd_q   <= BLANK_CODE;
      dp_n_q        <= SEG_OFF;
      frame_start_q <= 1'b0;
      upd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      an_n_q        <= an_n_d;
      digit_bcd_q   <= digit_bcd_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
      upd_ready_q   <= ~pend_full_d;
    end
  end

  assign upd_ready   = upd_ready_q;
  assign an_n        = an_n_q;
  assign digit_bcd   = digit_bcd_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-clock lit slots and 2-clock guards (24-clock frame).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_bcd;
  logic [3:0]  upd_dp;
  logic [3:0]  digit_bcd;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;

  int checks;
  int errors;
  int pos;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .GUARD_CYCLES (2),
    .LZ_BLANK     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_bcd     (upd_bcd),
    .upd_dp      (upd_dp),
    .digit_bcd   (digit_bcd),
    .an_n        (an_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // pos = clock index within the 24-clock frame; 0 is the frame_start cycle
  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 24;
  endtask

  task automatic goto(input int p);
    for (int k = 0; k < 24 && pos != p; k++) tick();
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] d);
    upd_bcd   = b;
    upd_dp    = d;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    upd_bcd   = 16'hBEEF;
    upd_dp    = 4'hF;
  endtask

  function automatic logic [3:0] anode_for(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    tick();
    checks += 5;
    if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an_n got %b want 1111", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL reset_digit got %h want f", digit_bcd); end
    if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_upd_ready got %b want 1", upd_ready); end
  endtask

  task automatic test_first_frame();
    logic [3:0] ea;
    int nfs;
    rst = 1'b0;
    tick();
    checks += 2;
    if (an_n !== 4'hF) begin errors++; $display("FAIL first_guard_an_n got %b want 1111", an_n); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL first_guard_fs got %b want 0", frame_start); end
    tick();
    pos = 0;
    checks += 3;
    if (an_n !== 4'b1110) begin errors++; $display("FAIL first_show_an_n got %b want 1110", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL first_show_digit got %h want f", digit_bcd); end
    if (frame_start !== 1'b1) begin errors++; $display("FAIL first_show_fs got %b want 1", frame_start); end
    nfs = 0;
    for (int p = 1; p < 24; p++) begin
      tick();
      if (frame_start === 1'b1) nfs++;
      ea = ((p % 6) < 4) ? anode_for(p / 6) : 4'hF;
      checks += 2;
      if (an_n !== ea) begin errors++; $display("FAIL blank_frame_an_n p=%0d got %b want %b", p, an_n, ea); end
      if (digit_bcd !== 4'hF) begin errors++; $display("FAIL blank_frame_digit p=%0d got %h want f", p, digit_bcd); end
    end
    checks++;
    if (nfs != 0) begin errors++; $display("FAIL blank_frame_fs_count got %0d want 0", nfs); end
    tick();
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period_fs got %b want 1", frame_start); end
  endtask

  task automatic test_update();
    logic [3:0] ed [4];
    ed = '{4'h4, 4'h3, 4'h2, 4'h1};
    goto(3);
    upd_bcd   = 16'h1234;
    upd_dp    = 4'b0100;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    upd_bcd   = 16'h9999;
    upd_dp    = 4'hF;
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_after_accept got %b want 0", upd_ready); end
    goto(12);
    checks += 3;
    if (an_n !== 4'b1011) begin errors++; $display("FAIL midframe_an_n got %b want 1011", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL midframe_digit_unchanged got %h want f", digit_bcd); end
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL pending_ready got %b want 0", upd_ready); end
    goto(0);
    checks += 2;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL update_fs got %b want 1", frame_start); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_consume got %b want 1", upd_ready); end
    for (int s = 0; s < 4; s++) begin
      goto(6 * s);
      checks += 3;
      if (an_n !== anode_for(s)) begin errors++; $display("FAIL update_an_n s=%0d got %b want %b", s, an_n, anode_for(s)); end
      if (digit_bcd !== ed[s]) begin errors++; $display("FAIL update_digit s=%0d got %h want %h", s, digit_bcd, ed[s]); end
      if (dp_n !== (s != 2)) begin errors++; $display("FAIL update_dp_n s=%0d got %b want %b", s, dp_n, (s != 2)); end
    end
  endtask

  task automatic test_lz();
    logic [3:0] ed [4];
    logic       edp [4];
    goto(19);
    load(16'h0050, 4'b1000);
    goto(0);
    ed  = '{4'h0, 4'h5, 4'hF, 4'hF};
    edp = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      goto(6 * s);
      checks += 2;
      if (digit_bcd !== ed[s]) begin errors++; $display("FAIL lz_0050_digit s=%0d got %h want %h", s, digit_bcd, ed[s]); end
      if (dp_n !== edp[s]) begin errors++; $display("FAIL lz_0050_dp_n s=%0d got %b want %b", s, dp_n, edp[s]); end
    end
    goto(19);
    load(16'h0000, 4'b0000);
    goto(0);
    ed = '{4'h0, 4'hF, 4'hF, 4'hF};
    for (int s = 0; s < 4; s++) begin
      goto(6 * s);
      checks += 2;
      if (digit_bcd !== ed[s]) begin errors++; $display("FAIL lz_0000_digit s=%0d got %h want %h", s, digit_bcd, ed[s]); end
      if (an_n !== anode_for(s)) begin errors++; $display("FAIL lz_0000_an_n s=%0d got %b want %b", s, an_n, anode_for(s)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    ea = '{4'h6, 4'h7, 4'h8, 4'h9};
    eb = '{4'h1, 4'h2, 4'h3, 4'h4};
    goto(20);
    load(16'h9876, 4'b0000);
    upd_bcd   = 16'h4321;
    upd_dp    = 4'b0000;
    upd_valid = 1'b1;
    tick();
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", upd_ready); end
    goto(0);
    checks += 2;
    if (digit_bcd !== 4'h6) begin errors++; $display("FAIL b2b_second_not_taken got %h want 6", digit_bcd); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_consume got %b want 1", upd_ready); end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got %b want 0", upd_ready); end
    for (int s = 1; s < 4; s++) begin
      goto(6 * s);
      checks++;
      if (digit_bcd !== ea[s]) begin errors++; $display("FAIL b2b_first_word s=%0d got %h want %h", s, digit_bcd, ea[s]); end
    end
    goto(0);
    for (int s = 0; s < 4; s++) begin
      goto(6 * s);
      checks++;
      if (digit_bcd !== eb[s]) begin errors++; $display("FAIL b2b_second_word s=%0d got %h want %h", s, digit_bcd, eb[s]); end
    end
  endtask

  task automatic test_enable();
    goto(13);
    checks++;
    if (digit_bcd !== 4'h3) begin errors++; $display("FAIL en_pre_digit got %h want 3", digit_bcd); end
    en = 1'b0;
    tick();
    checks += 3;
    if (an_n !== 4'hF) begin errors++; $display("FAIL en_off_an_n got %b want 1111", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL en_off_digit got %h want f", digit_bcd); end
    if (dp_n !== 1'b1) begin errors++; $display("FAIL en_off_dp_n got %b want 1", dp_n); end
    load(16'h0007, 4'b0001);
    tick();
    tick();
    checks += 2;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL en_off_handshake got %b want 0", upd_ready); end
    if (an_n !== 4'hF) begin errors++; $display("FAIL en_off_hold_an_n got %b want 1111", an_n); end
    en = 1'b1;
    tick();
    checks++;
    if (an_n !== 4'hF) begin errors++; $display("FAIL en_rise_guard_an_n got %b want 1111", an_n); end
    tick();
    pos = 0;
    checks += 5;
    if (an_n !== 4'b1110) begin errors++; $display("FAIL en_rise_an_n got %b want 1110", an_n); end
    if (frame_start !== 1'b1) begin errors++; $display("FAIL en_rise_fs got %b want 1", frame_start); end
    if (digit_bcd !== 4'h7) begin errors++; $display("FAIL en_rise_digit got %h want 7", digit_bcd); end
    if (dp_n !== 1'b0) begin errors++; $display("FAIL en_rise_dp_n got %b want 0", dp_n); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL en_rise_ready got %b want 1", upd_ready); end
    goto(6);
    checks++;
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL en_rise_lz_digit1 got %h want f", digit_bcd); end
  endtask

  task automatic test_reset_mid();
    goto(7);
    load(16'h5555, 4'b1111);
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_pending got %b want 0", upd_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (an_n !== 4'hF) begin errors++; $display("FAIL rst_mid_an_n got %b want 1111", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL rst_mid_digit got %h want f", digit_bcd); end
    if (dp_n !== 1'b1) begin errors++; $display("FAIL rst_mid_dp_n got %b want 1", dp_n); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_mid_fs got %b want 0", frame_start); end
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", upd_ready); end
    tick();
    tick();
    pos = 0;
    checks += 3;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs got %b want 1", frame_start); end
    if (an_n !== 4'b1110) begin errors++; $display("FAIL rst_restart_an_n got %b want 1110", an_n); end
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL rst_pending_discarded got %h want f", digit_bcd); end
    for (int s = 1; s < 4; s++) begin
      goto(6 * s);
      checks += 2;
      if (digit_bcd !== 4'hF) begin errors++; $display("FAIL rst_blank_digit s=%0d got %h want f", s, digit_bcd); end
      if (dp_n !== 1'b1) begin errors++; $display("FAIL rst_blank_dp_n s=%0d got %b want 1", s, dp_n); end
    end
    goto(0);
    checks++;
    if (digit_bcd !== 4'hF) begin errors++; $display("FAIL rst_still_blank got %h want f", digit_bcd); end
    load(16'h0042, 4'b0000);
    goto(0);
    checks++;
    if (digit_bcd !== 4'h2) begin errors++; $display("FAIL rst_new_word_d0 got %h want 2", digit_bcd); end
    goto(6);
    checks++;
    if (digit_bcd !== 4'h4) begin errors++; $display("FAIL rst_new_word_d1 got %h want 4", digit_bcd); end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    upd_valid = 1'b0;
    upd_bcd   = 16'h0000;
    upd_dp    = 4'h0;
    checks    = 0;
    errors    = 0;
    pos       = 0;
    test_reset();
    test_first_frame();
    test_update();
    test_lz();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
